// File: rtl/irq_arbiter_if.sv
// Register-bridge and CPU interrupt handshake bundle for irq_arbiter.
// The slave modport is the arbiter side; master is the bridge/CPU side.
interface irq_arbiter_if;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        int_req;
    logic [2:0]  int_code;
    logic        int_ack;
    logic        int_eret;
    logic        busy;

    modport master (
        output reg_we, reg_addr, reg_wdata, int_ack, int_eret,
        input  reg_rdata, int_req, int_code, busy
    );

    modport slave (
        input  reg_we, reg_addr, reg_wdata, int_ack, int_eret,
        output reg_rdata, int_req, int_code, busy
    );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-triggered, fixed-priority interrupt arbiter with MASK/PEND/ACTIVE/CTRL registers.
// Define IRQ_ARBITER_SYNC_EN to insert a two-flop synchronizer on every irq_src line.
module irq_arbiter #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    irq_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state_reg;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] prev_reg;
    logic [NSRC-1:0] pend_reg;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic            gie_reg;
    logic            int_req_reg;
    logic [2:0]      int_code_reg;
    logic            busy_reg;
    logic [2:0]      winner;
    logic [1:0]      arm_cnt_reg;
    logic            armed;
    logic            w1c;
    logic            ack_take;
    logic            unused_wdata;

`ifdef IRQ_ARBITER_SYNC_EN
    localparam int ARM_DEPTH = 3;
    logic [NSRC-1:0] sync1_reg;
    logic [NSRC-1:0] sync2_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_src;
            sync2_reg <= sync1_reg;
        end
    end
    assign src_s = sync2_reg;
`else
    localparam int ARM_DEPTH = 1;
    assign src_s = irq_src;
`endif

    // Edge detection stays disarmed until prev holds a real sample of the line,
    // so a source already high at reset release is not seen as a new edge.
    assign armed    = (arm_cnt_reg == 2'(ARM_DEPTH));
    assign eligible = pend_reg & mask_reg;
    assign w1c      = bus.reg_we && (bus.reg_addr == 2'd1);
    assign ack_take = (state_reg == REQ) && bus.int_ack && gie_reg && (eligible != '0);
    assign unused_wdata = ^bus.reg_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign rise[gi]      = armed & src_s[gi] & ~prev_reg[gi];
            assign clr[gi]       = (w1c & bus.reg_wdata[gi])
                                 | (ack_take & (int_code_reg == 3'(gi)));
            // A new edge wins over any clear in the same cycle.
            assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~clr[gi]);
        end
    endgenerate

    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg    <= '0;
            pend_reg    <= '0;
            mask_reg    <= '0;
            gie_reg     <= 1'b0;
            arm_cnt_reg <= 2'd0;
        end else begin
            prev_reg <= src_s;
            pend_reg <= pend_next;
            if (!armed) arm_cnt_reg <= arm_cnt_reg + 2'd1;
            if (bus.reg_we && bus.reg_addr == 2'd0) mask_reg <= bus.reg_wdata[NSRC-1:0];
            if (bus.reg_we && bus.reg_addr == 2'd3) gie_reg  <= bus.reg_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            int_req_reg  <= 1'b0;
            int_code_reg <= 3'd0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gie_reg && eligible != '0) begin
                        state_reg    <= REQ;
                        int_req_reg  <= 1'b1;
                        int_code_reg <= winner;
                    end
                end
                REQ: begin
                    if (!gie_reg || eligible == '0) begin
                        state_reg   <= IDLE;
                        int_req_reg <= 1'b0;
                    end else if (bus.int_ack) begin
                        state_reg   <= SERVICE;
                        int_req_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                    end else begin
                        int_code_reg <= winner;
                    end
                end
                SERVICE: begin
                    if (bus.int_eret) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    int_req_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.reg_rdata = 32'd0;
        case (bus.reg_addr)
            2'd0:    bus.reg_rdata = 32'(mask_reg);
            2'd1:    bus.reg_rdata = 32'(pend_reg);
            2'd2:    bus.reg_rdata = {busy_reg, 28'd0, int_code_reg};
            default: bus.reg_rdata = {31'd0, gie_reg};
        endcase
    end

    assign bus.int_req  = int_req_reg;
    assign bus.int_code = int_code_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed register/handshake checks plus a queue of
// expected serviced codes that is compared whenever the CPU acknowledges.
module tb_irq_arbiter;

    logic       clk;
    logic       reset;
    logic [5:0] irq_src;
    int         n_tests;
    int         n_fail;
    logic [2:0] exp_q[$];
    logic [31:0] rd_val;

    irq_arbiter_if bus();

    irq_arbiter #(.NSRC(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_src(irq_src),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        bus.reg_addr = addr;
        #1;
        data = bus.reg_rdata;
    endtask

    task automatic ack(input logic [2:0] code);
        exp_q.push_back(code);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic eret();
        bus.int_eret = 1'b1;
        tick();
        bus.int_eret = 1'b0;
    endtask

    // Scoreboard side: an accepted request must carry the next expected code.
    always @(negedge clk) begin
        if (bus.int_ack && bus.int_req) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [2:0] exp_code;
                exp_code = exp_q.pop_front();
                $display("[TB] ack code %0d (expected %0d)", bus.int_code, exp_code);
                chk("sb_code", 32'(bus.int_code), 32'(exp_code));
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        irq_src = '0;
        bus.reg_we = 1'b0;
        bus.reg_addr = 2'd0;
        bus.reg_wdata = 32'd0;
        bus.int_ack = 1'b0;
        bus.int_eret = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int_req", 32'(bus.int_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_code", 32'(bus.int_code), 32'd0);
        reset = 1'b1;
        tick();
        rd(2'd0, rd_val); chk("rst_mask", rd_val, 32'd0);
        rd(2'd1, rd_val); chk("rst_pend", rd_val, 32'd0);
        rd(2'd2, rd_val); chk("rst_active", rd_val, 32'd0);
        rd(2'd3, rd_val); chk("rst_ctrl", rd_val, 32'd0);

        // Register widths
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, rd_val); chk("mask_rw", rd_val, 32'h0000_003F);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, rd_val); chk("ctrl_rw", rd_val, 32'h0000_0001);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, rd_val); chk("active_ro", rd_val, 32'd0);

        // Single source, latency and service cycle
        irq_src[1] = 1'b1;
        tick();
        rd(2'd1, rd_val); chk("lat_pend", rd_val, 32'h02);
        chk("lat_req_early", 32'(bus.int_req), 32'd0);
        tick();
        chk("lat_req", 32'(bus.int_req), 32'd1);
        chk("lat_code", 32'(bus.int_code), 32'd1);
        irq_src[1] = 1'b0;
        ack(3'd1);
        chk("svc_busy", 32'(bus.busy), 32'd1);
        chk("svc_req", 32'(bus.int_req), 32'd0);
        rd(2'd1, rd_val); chk("svc_pend", rd_val, 32'd0);
        rd(2'd2, rd_val); chk("svc_active", rd_val, 32'h8000_0001);
        eret();
        chk("eret_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("eret_idle", 32'(bus.int_req), 32'd0);

        // Simultaneous edges, priority and back-to-back service
        irq_src = 6'b000101;
        tick();
        rd(2'd1, rd_val); chk("dual_pend", rd_val, 32'h05);
        tick();
        chk("dual_req", 32'(bus.int_req), 32'd1);
        chk("dual_code", 32'(bus.int_code), 32'd0);
        irq_src = '0;
        ack(3'd0);
        chk("dual_busy", 32'(bus.busy), 32'd1);
        rd(2'd1, rd_val); chk("dual_pend_ack", rd_val, 32'h04);
        rd(2'd2, rd_val); chk("dual_active", rd_val, 32'h8000_0000);
        eret();
        chk("b2b_gap_req", 32'(bus.int_req), 32'd0);
        chk("b2b_gap_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("b2b_req", 32'(bus.int_req), 32'd1);
        chk("b2b_code", 32'(bus.int_code), 32'd2);
        ack(3'd2);
        eret();

        // Software withdraws the request before ack
        irq_src[1] = 1'b1;
        tick();
        tick();
        chk("w1c_req", 32'(bus.int_req), 32'd1);
        irq_src = '0;
        wr(2'd1, 32'h02);
        tick();
        chk("w1c_drop", 32'(bus.int_req), 32'd0);
        chk("w1c_busy", 32'(bus.busy), 32'd0);
        rd(2'd1, rd_val); chk("w1c_pend", rd_val, 32'd0);
        tick();
        chk("w1c_stay_idle", 32'(bus.int_req), 32'd0);

        // Preemption before ack, then a new edge during SERVICE
        irq_src[3] = 1'b1;
        tick();
        tick();
        chk("pre_code3", 32'(bus.int_code), 32'd3);
        irq_src[1] = 1'b1;
        tick();
        tick();
        chk("pre_req", 32'(bus.int_req), 32'd1);
        chk("pre_code1", 32'(bus.int_code), 32'd1);
        irq_src = '0;
        ack(3'd1);
        rd(2'd1, rd_val); chk("pre_pend", rd_val, 32'h08);
        irq_src[0] = 1'b1;
        tick();
        rd(2'd1, rd_val); chk("nest_pend", rd_val, 32'h09);
        chk("nest_req", 32'(bus.int_req), 32'd0);
        tick();
        tick();
        chk("nest_req_hold", 32'(bus.int_req), 32'd0);
        chk("nest_busy", 32'(bus.busy), 32'd1);
        irq_src = '0;
        eret();
        chk("nest_eret_req", 32'(bus.int_req), 32'd0);
        tick();
        chk("nest_next_code", 32'(bus.int_code), 32'd0);
        ack(3'd0);
        eret();
        tick();
        chk("nest_last_code", 32'(bus.int_code), 32'd3);
        ack(3'd3);
        eret();

        // GIE gating, stray ack/eret, GIE drop in REQ, mask gating
        wr(2'd3, 32'd0);
        irq_src[4] = 1'b1;
        tick();
        tick();
        chk("gie_off_req", 32'(bus.int_req), 32'd0);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk("stray_ack_busy", 32'(bus.busy), 32'd0);
        rd(2'd1, rd_val); chk("stray_ack_pend", rd_val, 32'h10);
        eret();
        chk("stray_eret_busy", 32'(bus.busy), 32'd0);
        irq_src = '0;
        wr(2'd3, 32'd1);
        tick();
        chk("gie_on_req", 32'(bus.int_req), 32'd1);
        chk("gie_on_code", 32'(bus.int_code), 32'd4);
        wr(2'd3, 32'd0);
        tick();
        chk("gie_drop_req", 32'(bus.int_req), 32'd0);
        wr(2'd0, 32'h0F);
        wr(2'd3, 32'd1);
        tick();
        tick();
        chk("masked_req", 32'(bus.int_req), 32'd0);
        wr(2'd1, 32'h10);
        rd(2'd1, rd_val); chk("masked_clr", rd_val, 32'd0);
        wr(2'd0, 32'h3F);

        // Set beats clear in the same cycle
        wr(2'd3, 32'd0);
        irq_src[1] = 1'b1;
        tick();
        rd(2'd1, rd_val); chk("race_pre", rd_val, 32'h02);
        irq_src[1] = 1'b0;
        tick();
        irq_src[1] = 1'b1;
        wr(2'd1, 32'h02);
        rd(2'd1, rd_val); chk("race_set_wins", rd_val, 32'h02);
        irq_src[1] = 1'b0;
        wr(2'd1, 32'h02);
        rd(2'd1, rd_val); chk("race_plain_clr", rd_val, 32'd0);

        // Asynchronous reset during SERVICE, with a line held high across release
        wr(2'd3, 32'd1);
        irq_src[5] = 1'b1;
        tick();
        tick();
        chk("ar_code", 32'(bus.int_code), 32'd5);
        irq_src[5] = 1'b0;
        ack(3'd5);
        chk("ar_busy_pre", 32'(bus.busy), 32'd1);
        irq_src[2] = 1'b1;
        reset = 1'b0;
        #1;
        chk("ar_req", 32'(bus.int_req), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        rd(2'd1, rd_val); chk("ar_pend", rd_val, 32'd0);
        rd(2'd0, rd_val); chk("ar_mask", rd_val, 32'd0);
        rd(2'd3, rd_val); chk("ar_ctrl", rd_val, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        rd(2'd1, rd_val); chk("held_src_pend", rd_val, 32'd0);
        wr(2'd0, 32'h3F);
        wr(2'd3, 32'd1);
        irq_src[2] = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        tick();
        rd(2'd1, rd_val); chk("post_rst_pend", rd_val, 32'h01);
        tick();
        chk("post_rst_req", 32'(bus.int_req), 32'd1);
        chk("post_rst_code", 32'(bus.int_code), 32'd0);
        irq_src = '0;
        ack(3'd0);
        eret();
        tick();
        chk("post_rst_idle", 32'(bus.int_req), 32'd0);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter: NSRC, 6, number of interrupt sources; legal range 1..8.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: irq_src  in  NSRC  level interrupt lines; bit0 Timer0 IRQ, bit1 Timer1 IRQ, bit2 external interrupt, higher bits spare.
REQ-005 Port: reg_we  in  1  register write strobe from bridge.
REQ-006 Port: reg_addr  in  2  word index: 0 MASK, 1 PEND, 2 ACTIVE, 3 CTRL.
REQ-007 Port: reg_wdata  in  32  write data.
REQ-008 Port: reg_rdata  out  32  read data, combinational from reg_addr.
REQ-009 Port: int_req  out  1  registered interrupt request to CPU.
REQ-010 Port: int_code  out  3  registered index of requested/serviced source.
REQ-011 Port: int_ack  in  1  CPU accepts request (one-cycle pulse).
REQ-012 Port: int_eret  in  1  CPU finished handler (one-cycle pulse).
REQ-013 Port: busy  out  1  high while in SERVICE.

Function
REQ-014 Edge detect: prev[i] registers irq_src[i]; rise[i] = irq_src[i] & ~prev[i].
REQ-015 PEND[i] sets on the edge where rise[i]=1; sticky until cleared.
REQ-016 PEND clear sources: write-1-to-clear via reg_addr=1, or ack of source i; a same-cycle set beats any clear.
REQ-017 MASK (addr 0): bits [NSRC-1:0] read/write; upper bits read 0.
REQ-018 CTRL (addr 2'd3): bit0 GIE read/write; other bits read 0.
REQ-019 ACTIVE (addr 2): {busy, 28'b0, int_code}; writes ignored.
REQ-020 eligible = PEND & MASK; winner = lowest set index (bit0 highest priority).
REQ-021 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-022 IDLE: GIE=1 and eligible!=0 -> REQ, latch int_code=winner.
REQ-023 REQ: int_req=1; int_code tracks current winner each cycle (a higher-priority arrival preempts before ack).
REQ-024 REQ: eligible becomes 0 or GIE cleared -> IDLE, int_req drops next edge.
REQ-025 REQ with int_ack=1 -> SERVICE; PEND[int_code] cleared on that edge; int_code frozen.
REQ-026 SERVICE: int_req=0, busy=1; no nesting; new edges only set PEND.
REQ-027 SERVICE with int_eret=1 -> IDLE; busy drops next edge.
REQ-028 int_ack outside REQ and int_eret outside SERVICE are ignored.
REQ-029 Latency: irq_src first sampled high at edge k -> PEND set after k -> int_req high after edge k+1.
REQ-030 Back-to-back: eligible still non-zero at eret -> IDLE for one cycle, then REQ.

Reset
REQ-031 reset low: state IDLE, PEND=0, MASK=0, GIE=0, prev=0, int_req=0, int_code=0, busy=0, immediately and asynchronously.
REQ-032 Reset asserted mid-REQ or mid-SERVICE discards the request; no ack/eret required after release.
REQ-033 An irq_src held high through reset release does not set PEND (prev=0 is overridden: first edge after release captures irq_src into prev without setting PEND).

Configuration
REQ-034 Macro IRQ_ARBITER_SYNC_EN defined: two-flop synchronizer (reset 0) on each irq_src bit before edge detect; REQ-029 latency grows by 2 cycles.
REQ-035 Macro undefined: irq_src feeds edge detect directly; no synchronizer flops.

Verification
REQ-036 MASK=0x3F, GIE=1, pulse irq_src[1] -> PEND=0x02, int_req=1, int_code=1 two edges later.
REQ-037 irq_src[2] and [0] rise same cycle -> int_code=0; ack -> PEND=0x04, busy=1; eret -> one idle cycle, then int_req=1, int_code=2.
REQ-038 In REQ (code 1), software writes 0x02 to PEND -> int_req=0 next edge, state IDLE, no ack needed.
REQ-039 In SERVICE, irq_src[0] rises -> PEND[0]=1, int_req stays 0 until eret.
REQ-040 Same cycle: W1C of PEND[1] and new rise on src1 -> PEND[1]=1.
REQ-041 reset low during SERVICE -> int_req=0, busy=0, PEND=0, MASK=0 without clock edge.
